msu_fill: RTL
=============

MSU_FILL -- requirements
Module: msu_fill

Interface
REQ-001 Parameter PULSE_LEN, default 4, meaning clkin cycles each strobe (status_reset_we, msu_address_ext_write) is held high; legal range 2..15.
REQ-002 clkin  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 fill_start  input  1  one-cycle pulse; latches fill_base, fill_len, fill_seek.
REQ-005 fill_base  input  14  first buffer address to write.
REQ-006 fill_len  input  15  byte count, 0..16384.
REQ-007 fill_seek  input  1  fill follows a data seek; the SNES read pointer is to be moved to fill_base.
REQ-008 byte_data  input  8  MCU data byte.
REQ-009 byte_valid  input  1  byte_data is valid.
REQ-010 byte_ready  output  1  block accepts a byte this cycle; transfer = byte_valid & byte_ready.
REQ-011 msu_status  input  7  MSU status vector; bit 4 = data_start.
REQ-012 fill_req  output  1  request to the MCU: msu_status[4] & ~busy.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 pgm_address  output  14  buffer write address.
REQ-015 pgm_data  output  8  buffer write data.
REQ-016 pgm_we  output  1  buffer write enable, active-low.
REQ-017 status_reset_bits  output  6;  status_set_bits  output  6;  status_reset_we  output  1  MSU status update strobe.
REQ-018 msu_address_ext  output  14;  msu_address_ext_write  output  1  SNES read-pointer load strobe.

Function
REQ-019 FSM states: IDLE, RECV, WRITE, ADDR, STAT, GAP.
REQ-020 IDLE, fill_start=1: latch inputs; set pgm_address=fill_base and remaining=fill_len; go to RECV, or to ADDR if fill_len=0.
REQ-021 IDLE: fill_start is the only way out; fill_start in any other state is ignored.
REQ-022 byte_ready is 1 only in RECV.
REQ-023 RECV, on a transfer: register byte_data onto pgm_data; go to WRITE.
REQ-024 WRITE lasts exactly 1 cycle: pgm_we=0 with pgm_address and pgm_data stable.
REQ-025 Leaving WRITE: pgm_address increments modulo 2^14 (3FFF wraps to 0000); remaining decrements; go to RECV if remaining>0, else ADDR.
REQ-026 Sustained streaming rate is one byte per 2 cycles.
REQ-027 ADDR: behaviour set by the Configuration section; ADDR then goes to STAT.
REQ-028 STAT: status_reset_bits=6'b010000 (clear data_busy/data_start) and status_set_bits=0; status_reset_we high for PULSE_LEN cycles; go to GAP.
REQ-029 GAP: all strobes low for PULSE_LEN cycles, so the MSU edge detector sees a clean rising edge; go to IDLE.
REQ-030 status_reset_bits and status_set_bits are held constant from the first cycle of STAT through the end of GAP.
REQ-031 Outside WRITE, pgm_we=1.
REQ-032 Outside STAT, status_reset_we=0.
REQ-033 Outside the ADDR strobe window, msu_address_ext_write=0.
REQ-034 fill_req drops in the same cycle that busy rises.

Reset
REQ-035 While rst_n=0, the FSM is in IDLE.
REQ-036 Reset values: pgm_we=1, byte_ready=0, busy=0, status_reset_we=0, msu_address_ext_write=0.
REQ-037 Reset values: pgm_address=0, pgm_data=0, msu_address_ext=0, status bit buses=0, remaining=0.
REQ-038 Reset mid-fill abandons the transfer with no status strobe; buffer contents are undefined.
REQ-039 After rst_n deasserts, the block accepts fill_start on the first clkin edge.

Configuration
REQ-040 With macro MSU_FILL_SEEK_SYNC_EN defined and fill_seek latched 1: ADDR drives msu_address_ext=latched fill_base and holds msu_address_ext_write high for PULSE_LEN cycles, then 2 idle cycles before STAT.
REQ-041 With MSU_FILL_SEEK_SYNC_EN defined and fill_seek latched 0, ADDR lasts 1 cycle with no strobe.
REQ-042 With MSU_FILL_SEEK_SYNC_EN undefined: ADDR always lasts 1 cycle; msu_address_ext_write stays 0 and msu_address_ext stays 0; fill_seek is ignored.

Verification
REQ-043 Scenario: fill_base=0x0100, fill_len=4, bytes AA,BB,CC,DD sent back-to-back -> four 1-cycle pgm_we lows at addresses 0x0100..0x0103 with those data, then status_reset_we high 4 cycles with bits=0x10, then busy=0.
REQ-044 Scenario: fill_base=0x3FFE, fill_len=3 -> writes at 0x3FFE, 0x3FFF, 0x0000.
REQ-045 Scenario: fill_len=0 -> no pgm_we pulse; status strobe within 3 cycles; busy returns to 0.
REQ-046 Scenario: byte_valid toggling every 3 cycles -> no lost or duplicated writes; pgm_we low only after each accepted byte.
REQ-047 Scenario: MSU_FILL_SEEK_SYNC_EN defined, fill_seek=1, fill_base=0x2000 -> msu_address_ext=0x2000 with a 4-cycle strobe strictly before status_reset_we rises; macro undefined -> no strobe.
REQ-048 Scenario: rst_n low after 2 of 8 bytes -> all outputs at reset values immediately; a new fill after release behaves as in REQ-043.

Source files
------------

// File: rtl/msu_fill.sv
// msu_fill: streams MCU bytes into the MSU buffer, then pulses the MSU status update.
// Optional macro MSU_FILL_SEEK_SYNC_EN: a seek fill also loads the SNES read pointer.
module msu_fill #(
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic        clkin,
    input  logic        rst_n,
    input  logic        fill_start,
    input  logic [13:0] fill_base,
    input  logic [14:0] fill_len,
    input  logic        fill_seek,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic [6:0]  msu_status,
    output logic        fill_req,
    output logic        busy,
    output logic [13:0] pgm_address,
    output logic [7:0]  pgm_data,
    output logic        pgm_we,
    output logic [5:0]  status_reset_bits,
    output logic [5:0]  status_set_bits,
    output logic        status_reset_we,
    output logic [13:0] msu_address_ext,
    output logic        msu_address_ext_write
);
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned LEN_W  = 15;
    localparam int unsigned CNT_W  = 4;
    localparam logic [5:0]  STAT_CLR = 6'b010000;

    typedef enum logic [2:0] {IDLE, RECV, WRITE, ADDR, STAT, GAP} state_t;

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic [CNT_W-1:0]  cnt;

`ifdef MSU_FILL_SEEK_SYNC_EN
    typedef enum logic [1:0] {PH_ARM, PH_STROBE, PH_HOLD} phase_t;
    phase_t            phase;
    logic              seek_q;
    logic [ADDR_W-1:0] base_q;
    logic              unused_in;
    assign unused_in = ^{msu_status[6:5], msu_status[3:0]};
`else
    logic              unused_in;
    assign unused_in = ^{fill_seek, msu_status[6:5], msu_status[3:0]};
    assign msu_address_ext       = '0;
    assign msu_address_ext_write = 1'b0;
`endif

    // Request a refill only while the block is free to take one.
    assign fill_req = msu_status[4] & ~busy;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            remaining         <= '0;
            cnt               <= '0;
            busy              <= 1'b0;
            byte_ready        <= 1'b0;
            pgm_address       <= '0;
            pgm_data          <= '0;
            pgm_we            <= 1'b1;
            status_reset_bits <= '0;
            status_set_bits   <= '0;
            status_reset_we   <= 1'b0;
`ifdef MSU_FILL_SEEK_SYNC_EN
            phase                 <= PH_ARM;
            seek_q                <= 1'b0;
            base_q                <= '0;
            msu_address_ext       <= '0;
            msu_address_ext_write <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        busy        <= 1'b1;
                        pgm_address <= fill_base;
                        remaining   <= fill_len;
`ifdef MSU_FILL_SEEK_SYNC_EN
                        seek_q <= fill_seek;
                        base_q <= fill_base;
                        phase  <= PH_ARM;
`endif
                        if (fill_len == '0) begin
                            state <= ADDR;
                        end else begin
                            state      <= RECV;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (byte_valid) begin
                        pgm_data   <= byte_data;
                        byte_ready <= 1'b0;
                        pgm_we     <= 1'b0;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    pgm_we      <= 1'b1;
                    pgm_address <= pgm_address + ADDR_W'(1);
                    remaining   <= remaining - LEN_W'(1);
                    if (remaining > LEN_W'(1)) begin
                        state      <= RECV;
                        byte_ready <= 1'b1;
                    end else begin
                        state <= ADDR;
                    end
                end
                ADDR: begin
`ifdef MSU_FILL_SEEK_SYNC_EN
                    // Seek fills: pointer strobe, two quiet cycles, then status.
                    case (phase)
                        PH_ARM: begin
                            if (seek_q) begin
                                msu_address_ext       <= base_q;
                                msu_address_ext_write <= 1'b1;
                                cnt                   <= CNT_W'(PULSE_LEN - 1);
                                phase                 <= PH_STROBE;
                            end else begin
                                state             <= STAT;
                                status_reset_bits <= STAT_CLR;
                                status_set_bits   <= '0;
                                status_reset_we   <= 1'b1;
                                cnt               <= CNT_W'(PULSE_LEN - 1);
                            end
                        end
                        PH_STROBE: begin
                            if (cnt == '0) begin
                                msu_address_ext_write <= 1'b0;
                                cnt                   <= CNT_W'(1);
                                phase                 <= PH_HOLD;
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                        default: begin
                            if (cnt == '0) begin
                                phase             <= PH_ARM;
                                state             <= STAT;
                                status_reset_bits <= STAT_CLR;
                                status_set_bits   <= '0;
                                status_reset_we   <= 1'b1;
                                cnt               <= CNT_W'(PULSE_LEN - 1);
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                    endcase
`else
                    state             <= STAT;
                    status_reset_bits <= STAT_CLR;
                    status_set_bits   <= '0;
                    status_reset_we   <= 1'b1;
                    cnt               <= CNT_W'(PULSE_LEN - 1);
`endif
                end
                STAT: begin
                    if (cnt == '0) begin
                        status_reset_we <= 1'b0;
                        cnt             <= CNT_W'(PULSE_LEN - 1);
                        state           <= GAP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    // Strobes stay low so the MSU sees a clean edge next time.
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
